// File: rtl/alu_md_seq_if.sv
// Handshake and operand/result bundle for alu_md_seq.
// The master issues operations and the slave is the ALU itself.
interface alu_md_seq_if #(
  parameter int N = 32
);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         ready;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] hi;
  logic         cout;
  logic         v;
  logic         z;
  logic         dbz;

  modport master (
    output start, op, a, b, cin,
    input  ready, done, result, hi, cout, v, z, dbz
  );

  modport slave (
    input  start, op, a, b, cin,
    output ready, done, result, hi, cout, v, z, dbz
  );
endinterface

// File: rtl/alu_md_seq.sv
// Registered ALU with iterative unsigned multiply/divide behind a start/done handshake.
// Define ALU_MD_DIV_EN to build the restoring divider; otherwise DIVU is a one-cycle unsupported op.
module alu_md_seq #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_md_seq_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_MULU  = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;
  localparam logic [2:0] OP_SCALE = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   result_q, result_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [2*N-1:0] work_q, work_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           done_q, done_d;
  logic           cout_q, cout_d;
  logic           v_q, v_d;
  logic           z_q, z_d;
  logic           dbz_q, dbz_d;

  logic [N-1:0]   b_eff, sum, scaled;
  logic           c_in_eff, c_top, c_msb, scale_v;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_step;

  // SUB reuses the adder as a + ~b + 1; c_msb recovers the carry into the MSB.
  always_comb begin
    b_eff    = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    c_in_eff = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
    {c_top, sum} = {1'b0, bus.a} + {1'b0, b_eff} + {{N{1'b0}}, c_in_eff};
    c_msb    = sum[N-1] ^ bus.a[N-1] ^ b_eff[N-1];
  end

  always_comb begin
    scaled  = '0;
    scale_v = 1'b0;
    case (bus.b[2:0])
      3'd0: scaled = $signed(bus.a) >>> 3;
      3'd1: scaled = $signed(bus.a) >>> 2;
      3'd2: scaled = $signed(bus.a) >>> 1;
      3'd3: scaled = bus.a;
      3'd4: begin
        scaled  = bus.a << 1;
        scale_v = ($signed(scaled) >>> 1) != $signed(bus.a);
      end
      3'd5: begin
        scaled  = bus.a << 2;
        scale_v = ($signed(scaled) >>> 2) != $signed(bus.a);
      end
      3'd6: begin
        scaled  = bus.a << 3;
        scale_v = ($signed(scaled) >>> 3) != $signed(bus.a);
      end
      default: scaled = '0;
    endcase
  end

  // work_q holds {partial high, multiplier} and shifts right once per iteration.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*N-1:N]} + {1'b0, (work_q[0] ? opnd_q : {N{1'b0}})};
    mul_step = {mul_sum, work_q[N-1:1]};
  end

`ifdef ALU_MD_DIV_EN
  logic [N:0]     div_shift, div_trial;
  logic [2*N-1:0] div_step;

  // Restoring division: work_q holds {remainder, dividend/quotient} and shifts left.
  always_comb begin
    div_shift = work_q[2*N-1:N-1];
    div_trial = div_shift - {1'b0, opnd_q};
    if (!div_trial[N]) begin
      div_step = {div_trial[N-1:0], work_q[N-2:0], 1'b1};
    end else begin
      div_step = {div_shift[N-1:0], work_q[N-2:0], 1'b0};
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    v_d      = v_q;
    z_d      = z_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_ADD, OP_SUB: begin
              done_d = 1'b1; result_d = sum; hi_d = '0;
              cout_d = c_top; v_d = c_top ^ c_msb; dbz_d = 1'b0;
            end
            OP_AND, OP_OR, OP_XOR: begin
              done_d = 1'b1; hi_d = '0; cout_d = 1'b0; v_d = 1'b0; dbz_d = 1'b0;
              if (bus.op == OP_AND)     result_d = bus.a & bus.b;
              else if (bus.op == OP_OR) result_d = bus.a | bus.b;
              else                      result_d = bus.a ^ bus.b;
            end
            OP_SCALE: begin
              done_d = 1'b1; result_d = scaled; hi_d = '0;
              cout_d = 1'b0; v_d = scale_v; dbz_d = 1'b0;
            end
            OP_MULU: begin
              work_d = {{N{1'b0}}, bus.b}; opnd_d = bus.a;
              cnt_d = '0; is_div_d = 1'b0; state_d = RUN;
            end
            OP_DIVU: begin
`ifdef ALU_MD_DIV_EN
              work_d = {{N{1'b0}}, bus.a}; opnd_d = bus.b;
              cnt_d = '0; is_div_d = 1'b1; state_d = RUN;
`else
              done_d = 1'b1; result_d = '0; hi_d = '0;
              cout_d = 1'b0; v_d = 1'b1; dbz_d = 1'b0;
`endif
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
`ifdef ALU_MD_DIV_EN
        work_d = is_div_q ? div_step : mul_step;
`else
        work_d = mul_step;
`endif
        if (cnt_q == CW'(N - 1)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = work_d[N-1:0];
          hi_d     = work_d[2*N-1:N];
          cout_d   = 1'b0;
          v_d      = !is_div_q && (work_d[2*N-1:N] != '0);
          dbz_d    = is_div_q && (opnd_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
    if (done_d) z_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      hi_q     <= '0;
      opnd_q   <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      v_q      <= v_d;
      z_q      <= z_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.hi     = hi_q;
  assign bus.cout   = cout_q;
  assign bus.v      = v_q;
  assign bus.z      = z_q;
  assign bus.dbz    = dbz_q;
endmodule

// File: tb/tb_alu_md_seq.sv
// Self-checking bench for alu_md_seq at N=8: directed vector table, multi-cycle corner
// sequences and random operations against an arithmetic reference model.
module tb_alu_md_seq;
  localparam int N = 8;
`ifdef ALU_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] er;
    logic [7:0] eh;
    logic       eco;
    logic       ev;
    logic       ez;
    logic       edz;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_count = 0;
  int   check_count = 0;

  alu_md_seq_if #(.N(N)) bus ();
  alu_md_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic cin);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    tick();
    bus.start = 1'b0;
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, output logic [7:0] r, output logic [7:0] h,
                                output logic co, output logic ov, output logic zz, output logic dz);
    int sa, sb, t, st, k;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t = 0; st = 0; k = 0;
    r = 8'h00; h = 8'h00; co = 1'b0; ov = 1'b0; dz = 1'b0;
    case (op)
      3'd0: begin
        t  = int'(a) + int'(b) + int'(cin);
        st = sa + sb + int'(cin);
        r  = t[7:0];
        co = (t > 255);
        ov = (st > 127) || (st < -128);
      end
      3'd1: begin
        t  = int'(a) - int'(b);
        st = sa - sb;
        r  = t[7:0];
        co = (a >= b);
        ov = (st > 127) || (st < -128);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        t  = int'(a) * int'(b);
        r  = t[7:0];
        h  = t[15:8];
        ov = (h != 8'h00);
      end
      3'd6: begin
        if (!DIV_EN) ov = 1'b1;
        else if (b == 8'h00) begin
          r = 8'hFF; h = a; dz = 1'b1;
        end else begin
          t  = int'(a) / int'(b);
          st = int'(a) % int'(b);
          r  = t[7:0];
          h  = st[7:0];
        end
      end
      default: begin
        k = int'(b[2:0]);
        if (k < 3)       t = sa >>> (3 - k);
        else if (k == 3) t = sa;
        else if (k < 7) begin
          t  = sa * (1 << (k - 3));
          ov = (t > 127) || (t < -128);
        end else t = 0;
        r = t[7:0];
      end
    endcase
    zz = (r == 8'h00);
  endfunction

  task automatic doOp(input string name, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic cin, input logic [7:0] er,
                      input logic [7:0] eh, input logic eco, input logic ev, input logic ez,
                      input logic edz);
    int waited, low;
    bit multi;
    multi  = (op == 3'd5) || (op == 3'd6 && DIV_EN);
    waited = 0;
    low    = 0;
    applyStimulus(op, a, b, cin);
    while (!bus.done && waited < 40) begin
      if (!bus.ready) low++;
      tick();
      waited++;
    end
    checkOutput({name, " latency"}, 32'(waited), multi ? 32'(N) : 32'd0);
    checkOutput({name, " ready_low"}, 32'(low), multi ? 32'(N) : 32'd0);
    checkOutput({name, " outputs"},
                32'({bus.ready, bus.result, bus.hi, bus.cout, bus.v, bus.z, bus.dbz}),
                32'({1'b1, er, eh, eco, ev, ez, edz}));
    tick();
    checkOutput({name, " done_drop"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    int waited;
    logic [2:0] rop;
    logic [7:0] ra, rb, mr, mh;
    logic rc, mco, mv, mz, mdz;

    vecs.push_back('{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd1, 8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd3, 8'h0F, 8'h30, 1'b0, 8'h3F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd4, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd5, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd5, 8'h0F, 8'h03, 1'b0, 8'h2D, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef ALU_MD_DIV_EN
    vecs.push_back('{3'd6, 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 8'd200, 8'd0, 1'b0, 8'hFF, 8'd200, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'd6, 8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0});
`else
    vecs.push_back('{3'd6, 8'd200, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd6, 8'd200, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd6, 8'd5, 8'd9, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0});
`endif
    vecs.push_back('{3'd7, 8'hF0, 8'h00, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 8'h20, 8'h06, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd7, 8'h55, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd7, 8'h40, 8'h04, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 8'hC0, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd7, 8'h81, 8'h02, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 8'h7F, 8'h03, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd0, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd1, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});

    bus.start = 1'b0; bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_state",
                32'({bus.ready, bus.done, bus.result, bus.hi, bus.cout, bus.v, bus.z, bus.dbz}),
                32'({1'b1, 1'b0, 8'h00, 8'h00, 4'b0000}));
    rst = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      doOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
           vecs[i].er, vecs[i].eh, vecs[i].eco, vecs[i].ev, vecs[i].ez, vecs[i].edz);
    end

    // Back-to-back SUB then AND: two consecutive done pulses.
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 8'h05; bus.b = 8'h05; bus.cin = 1'b0;
    tick();
    checkOutput("b2b_sub", 32'({bus.done, bus.result, bus.cout, bus.v, bus.z}),
                32'({1'b1, 8'h00, 1'b1, 1'b0, 1'b1}));
    bus.op = 3'd2; bus.a = 8'hF0; bus.b = 8'h3C;
    tick();
    bus.start = 1'b0;
    checkOutput("b2b_and", 32'({bus.done, bus.result, bus.cout, bus.v, bus.z}),
                32'({1'b1, 8'h30, 1'b0, 1'b0, 1'b0}));
    tick();
    checkOutput("b2b_done_drop", 32'(bus.done), 32'd0);

    // MULU with a start and operand change while running.
    applyStimulus(3'd5, 8'hFF, 8'hFF, 1'b0);
    tick();
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 8'h01; bus.b = 8'h01;
    tick();
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    waited = 0;
    while (!bus.done && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput("mul_ignore latency", 32'(waited), 32'(N - 2));
    checkOutput("mul_ignore outputs", 32'({bus.result, bus.hi, bus.v, bus.dbz}),
                32'({8'h01, 8'hFE, 1'b1, 1'b0}));
    tick();
    checkOutput("mul_ignore no_extra_done", 32'(bus.done), 32'd0);

    // Reset three cycles into a MULU aborts it.
    applyStimulus(3'd5, 8'h12, 8'h34, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_state",
                32'({bus.ready, bus.done, bus.result, bus.hi, bus.cout, bus.v, bus.z, bus.dbz}),
                32'({1'b1, 1'b0, 8'h00, 8'h00, 4'b0000}));
    doOp("after_abort_add", 3'd0, 8'h01, 8'h02, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset and start together: the start is dropped.
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 8'h11; bus.b = 8'h22;
    tick();
    bus.start = 1'b0;
    rst = 1'b0;
    checkOutput("rst_start done", 32'({bus.done, bus.result}), 32'({1'b0, 8'h00}));
    tick();
    checkOutput("rst_start dropped", 32'({bus.done, bus.result}), 32'({1'b0, 8'h00}));

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      if (i % 10 == 0) rb = 8'h00;
      model(rop, ra, rb, rc, mr, mh, mco, mv, mz, mdz);
      doOp($sformatf("rand%0d op%0d a%h b%h", i, rop, ra, rb), rop, ra, rb, rc,
           mr, mh, mco, mv, mz, mdz);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/alu_md_seq.md
# alu_md_seq

Parametrised sequential ALU for the pipelined processor datapath: extends the N-bit ripple ALU and the shift-based multiply/divide-by-power-of-two scaler with registered results, condition flags, and iterative unsigned multiply and divide behind a start/done handshake. Single-cycle operations issue back-to-back. Multiply and divide stall the issuing stage via `ready` for N cycles.

## Interface
Parameters:
- `N` — default 32 — operand/result width, must be ≥ 4.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset; synchronous, active-high.
- `start`  in  1  — issue request; sampled only when `ready`=1.
- `op`  in  3  — 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MULU, 6 DIVU, 7 SCALE.
- `a`, `b`  in  N  — operands.
- `cin`  in  1  — carry-in for ADD only.
- `ready`  out  1  — block idle, able to accept `start`.
- `done`  out  1  — one-cycle pulse: `result`/`hi`/flags valid and updated.
- `result`  out  N  — sum, logic result, product low half, quotient, or scaled value.
- `hi`  out  N  — product high half (MULU) or remainder (DIVU); 0 for all other ops.
- `cout`, `v`, `z`, `dbz`  out  1 each — carry, overflow, zero, divide-by-zero.

## Operation
- States: IDLE, RUN. Reset → IDLE; `ready`=1; `done`, `result`, `hi`, all flags = 0; iteration counter = 0.
- IDLE with `start`=1 and op ∈ {0–4, 7}: result/flags registered at that edge; state stays IDLE.
- IDLE with `start`=1 and op ∈ {5, 6}: operands latched, counter cleared, → RUN.
- RUN: one iteration per edge, with N iterations in total; after the Nth, outputs are written and the state returns to IDLE.
- `start` while RUN is ignored. Operand changes during RUN do not affect the result.
- ADD: `a+b+cin`. SUB: `a+~b+1`, with `cin` ignored.
  - `cout` = carry[N].
  - `v` = carry[N]^carry[N-1].
- AND/OR/XOR: bitwise; `cout`=`v`=0.
- MULU: shift-add, 2N-bit unsigned product; {`hi`,`result`} = a*b.
  - `v` = (`hi`≠0).
  - `cout`=0.
- DIVU: restoring, unsigned; `result` = a/b, `hi` = a%b.
  - If b=0: `result` = all ones, `hi` = a, `dbz`=1, `v`=0.
  - `dbz`=0 for every other op/operand.
- SCALE: arithmetic shift of signed `a` by code `b[2:0]`:
  - 0: >>>3; 1: >>>2; 2: >>>1; 3: unchanged.
  - 4: <<<1; 5: <<<2; 6: <<<3; 7: result 0.
  - `v`=1 iff a left shift loses significance (result>>>k ≠ a); else 0.
  - `cout`=0.
- `z` = (`result`==0) for every op; `hi` is not considered.
- Outputs hold their last values until the next `done`.

## Timing
- Single-cycle ops: `start` sampled at edge k; `result`/flags valid and `done`=1 in cycle k+1. Issue rate 1/cycle.
- MULU/DIVU: `start` at edge k; `ready`=0 for cycles k+1…k+N; outputs written at edge k+N; `done`=1 and `ready`=1 in cycle k+N+1 (latency N+1 cycles).
- A new `start` is accepted in the same cycle `done` is high.
- `done` lasts exactly one cycle and is never asserted without a preceding accepted `start`.
- `rst` mid-RUN aborts the operation. Next cycle: IDLE, all outputs 0, no `done`.
- `rst` and `start` in the same cycle: reset wins and the start is dropped.

## Configuration
- `ALU_MD_DIV_EN` defined: iterative divider compiled in; DIVU behaves as specified.
- Undefined: no divider hardware. DIVU completes as a single-cycle op with `result`=0, `hi`=0, `dbz`=0, `v`=1 (unsupported op); `ready` is never deasserted by DIVU.

## Test plan
- N=8, ADD a=0x7F b=0x01 cin=0 → cycle after start: result 0x80, v=1, cout=0, z=0, done=1.
- N=8, SUB a=0x05 b=0x05 → result 0x00, z=1, cout=1, v=0; then issue AND back-to-back next cycle → two consecutive `done` pulses.
- N=8, MULU a=0xFF b=0xFF → `ready` low 8 cycles, then done with hi=0xFE result=0x01 v=1; a `start` during RUN is ignored.
- N=8, DIVU a=200 b=7 → result 28, hi 4; DIVU b=0 → result 0xFF, hi 200, dbz=1 (with `ALU_MD_DIV_EN`); without it → result 0, v=1, single-cycle.
- N=8, SCALE a=0xF0 (−16) b=0 → 0xFE; b=6 a=0x20 → 0x00 with v=1; b=7 → 0x00, z=1.
- N=8, assert `rst` 3 cycles into a MULU → next cycle ready=1, done=0, result=hi=0, flags 0; a following ADD completes normally.
